// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one result bit per RUN cycle, LSB first,
// with a registered difference and final borrow presented on the RUN->DONE edge.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic w_d1;
  logic w_b1;
  logic w_di;
  logic w_b2;
  logic w_bout;

  // Two cascaded half-subtractors on the current LSBs
  assign w_d1   = r_a[0] ^ r_b[0];
  assign w_b1   = ~r_a[0] & r_b[0];
  assign w_di   = w_d1 ^ r_bin;
  assign w_b2   = ~w_d1 & r_bin;
  assign w_bout = w_b1 | w_b2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_cnt   <= '0;
            r_bin   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= {w_di, r_res[WIDTH-1:1]};
          r_bin <= w_bout;
          if (r_cnt == LAST) begin
            // Hold the counter at its last value so it never wraps
            r_diff   <= {w_di, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): latency, results, start
// filtering, back-to-back throughput and mid-operation reset.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cyc_1;
  int done_cyc_2;
  logic [7:0] last_diff;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_a          (a),
    .i_b          (b),
    .o_busy       (busy),
    .o_done       (done),
    .o_diff       (diff),
    .o_borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one operation at a negedge and waits for its done pulse.
  // Returns on the negedge after DONE, i.e. the first IDLE cycle.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_d, input logic exp_bo,
                       input string tag, output int done_at);
    int lat;
    int busy_cnt;
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      if (lat == 4) check(diff, last_diff, {tag, "_diff_hold"});
      a = ~av; b = ~bv;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    done_at = cyc;
    check(lat, 9, {tag, "_latency"});
    check(busy_cnt, 9, {tag, "_busy_cycles"});
    check(diff, exp_d, {tag, "_diff"});
    check(borrow_out, exp_bo, {tag, "_borrow"});
    last_diff = exp_d;
    @(negedge clk);
    check({busy, done}, 2'b00, {tag, "_idle_after"});
  endtask

  initial begin
    int d;
    int n_done;
    start = 1'b0; a = '0; b = '0; rst_n = 1'b0;
    last_diff = 8'h00;
    repeat (2) @(negedge clk);
    check({busy, done, borrow_out}, 3'b000, "reset_ctl");
    check(diff, 8'h00, "reset_diff");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check({busy, done}, 2'b00, "idle_no_start");

    do_op(8'h05, 8'h03, 8'h02, 1'b0, "op_05_03", d);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, "op_03_05", d);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, "op_00_FF", d);
    // Back-to-back: second start in the first IDLE cycle after DONE
    do_op(8'hA5, 8'hA5, 8'h00, 1'b0, "op_A5_A5", done_cyc_1);
    do_op(8'hFF, 8'h00, 8'hFF, 1'b0, "op_FF_00", done_cyc_2);
    check(done_cyc_2 - done_cyc_1, 10, "b2b_done_spacing");

    // start held high through RUN and DONE, operands changed after acceptance
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h00; b = 8'h00;
    n_done = 0;
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    check(done, 1'b1, "held_done_seen");
    check(diff, 8'h0F, "held_diff");
    check(borrow_out, 1'b0, "held_borrow");
    @(negedge clk);
    check(busy, 1'b0, "held_idle_after_done");
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check(n_done, 0, "held_no_requeue");
    last_diff = 8'h0F;

    // Reset in the 4th RUN cycle aborts without a done pulse
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check(busy, 1'b1, "pre_reset_busy");
    rst_n = 1'b0;
    #1;
    check({busy, done, borrow_out}, 3'b000, "midrun_reset_ctl");
    check(diff, 8'h00, "midrun_reset_diff");
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check(n_done, 0, "post_reset_quiet");
    check(diff, 8'h00, "post_reset_diff");
    last_diff = 8'h00;
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, "op_80_01", d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while state is RUN or DONE.
REQ-008 done  output  1  one-cycle completion pulse, high only in DONE.
REQ-009 diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  registered final borrow; 1 iff a < b unsigned.

Function
REQ-011 The block SHALL be an FSM with states IDLE, RUN and DONE.
REQ-012 It SHALL compute the result bit-serially, LSB first, one bit per RUN cycle.
REQ-013 Each bit SHALL be formed by two cascaded half-subtractor stages:
- d1 = ai ^ bi, b1 = ~ai & bi
- di = d1 ^ bin, b2 = ~d1 & bin
- bout = b1 | b2
REQ-014 bin SHALL be a borrow register, cleared to 0 when start is accepted and loaded with bout each RUN cycle.
REQ-015 IDLE with start=1: SHALL latch a and b into internal shift registers, clear the bit counter and bin, and go to RUN.
REQ-016 IDLE with start=0: SHALL stay in IDLE.
REQ-017 Each RUN cycle SHALL:
- shift both operand registers right by one;
- shift di into the MSB of an internal result shift register;
- increment the bit counter.
REQ-018 RUN SHALL go to DONE on the cycle the counter equals WIDTH-1, i.e. after exactly WIDTH RUN cycles.
REQ-019 On the RUN->DONE edge, diff SHALL load the full result register and borrow_out SHALL load the final bout.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle after clock edge WIDTH+1, counting the edge that accepted start as edge 1.
REQ-022 Throughput: a new start SHALL be accepted no earlier than the first IDLE cycle after DONE, giving a minimum period of WIDTH+2 cycles.
REQ-023 start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-024 a and b changes after acceptance SHALL have no effect on the operation in progress.
REQ-025 diff and borrow_out SHALL hold their last values in every cycle except the RUN->DONE edge, including throughout a following operation.
REQ-026 busy SHALL be combinationally derived from state (state != IDLE).
REQ-027 done SHALL be combinationally derived from state (state == DONE).
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap during a valid operation.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE, counter=0, bin=0;
- operand and result shift registers = 0;
- diff=0, borrow_out=0, busy=0, done=0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse, leaving diff and borrow_out at 0.
REQ-031 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-032 a=8'h05, b=8'h03, start 1 cycle -> done pulse 9 edges later, diff=8'h02, borrow_out=0, busy high for 9 cycles.
REQ-033 a=8'h03, b=8'h05 -> diff=8'hFE, borrow_out=1; a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1.
REQ-034 a=8'hA5, b=8'hA5 -> diff=8'h00, borrow_out=0; then a=8'hFF, b=8'h00 -> diff=8'hFF, borrow_out=0.
REQ-035 start=1 with a=8'h10, b=8'h01 and held high; a/b changed to 8'h00 in RUN -> only one done, diff=8'h0F.
REQ-036 Second start is accepted in the first IDLE cycle after done -> done exactly 10 cycles after the first done.
REQ-037 rst_n pulsed low at RUN cycle 4 of a=8'h80, b=8'h01 -> no done, all outputs 0; next op 8'h80-8'h01 -> diff=8'h7F, borrow_out=0.
